// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: valid/ready pipeline register with a 2-entry skid buffer, flush, and control masking on bubbles; ports clk/reset/flush, in_valid/in_ready/in_data/in_ctrl, out_valid/out_ready/out_data/out_ctrl, occupancy
module elastic_pipe_reg #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  logic [1:0] state;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic accept, drain;
  always_comb begin
    in_ready = state != FULL;
    out_valid = state != EMPTY;
    accept = in_valid & in_ready;
    drain = out_valid & out_ready;
    out_data = main_data;
    out_ctrl = out_valid ? main_ctrl : '0;
    occupancy = state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      state <= state + {1'b0, accept} - {1'b0, drain};
      if (accept && (state == EMPTY || (state == ONE && drain))) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (drain && state == FULL) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (accept && state == ONE && !drain) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: directed and random checks of elastic_pipe_reg against a queue-based reference
module tb_elastic_pipe_reg;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [15:0] in_data = '0, out_data;
  logic [7:0] in_ctrl = '0, out_ctrl;
  logic [1:0] occupancy;
  logic [23:0] mdl[$];
  bit armed = 0;
  int checks = 0, errors = 0;
  elastic_pipe_reg #(.DATA_W(16), .CTRL_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin : model
    bit acc, drn;
    if (reset) begin
      mdl.delete();
      armed = 1;
    end else if (flush) begin
      mdl.delete();
    end else begin
      acc = in_valid && mdl.size() < 2;
      drn = mdl.size() > 0 && out_ready;
      if (drn) void'(mdl.pop_front());
      if (acc) mdl.push_back({in_data, in_ctrl});
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("occupancy", occupancy, mdl.size());
      chk("in_ready", in_ready, mdl.size() < 2);
      chk("out_valid", out_valid, mdl.size() > 0);
      if (mdl.size() > 0) begin
        chk("head_data", out_data, mdl[0][23:8]);
        chk("head_ctrl", out_ctrl, mdl[0][7:0]);
      end else begin
        chk("bubble_ctrl", out_ctrl, 0);
      end
    end
  end
  task automatic cyc(input logic iv, input logic [15:0] d, input logic [7:0] c,
                     input logic ordy, input logic fl = 0, input logic rs = 0);
    in_valid = iv;
    in_data = d;
    in_ctrl = c;
    out_ready = ordy;
    flush = fl;
    reset = rs;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_data", out_data, 0);
    chk("rst_occ", occupancy, 0);
    cyc(1, 16'h1111, 8'h11, 1);
    chk("t2_a", out_data, 16'h1111);
    cyc(1, 16'h2222, 8'h22, 1);
    chk("t2_b", out_data, 16'h2222);
    chk("t2_ready", in_ready, 1);
    cyc(1, 16'h3333, 8'h33, 1);
    chk("t2_c", out_data, 16'h3333);
    chk("t2_occ", occupancy, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 16'hAAAA, 8'h0A, 0);
    cyc(1, 16'hBBBB, 8'h0B, 0);
    chk("t3_occ", occupancy, 2);
    chk("t3_ready", in_ready, 0);
    cyc(1, 16'hCCCC, 8'h0C, 0);
    chk("t3_stall", out_data, 16'hAAAA);
    cyc(1, 16'hCCCC, 8'h0C, 1);
    chk("t3_b", out_data, 16'hBBBB);
    cyc(1, 16'hCCCC, 8'h0C, 1);
    chk("t3_c", out_data, 16'hCCCC);
    cyc(0, 0, 0, 1);
    chk("t3_empty", out_valid, 0);
    cyc(1, 16'h0101, 8'h01, 0);
    cyc(1, 16'h0202, 8'h02, 0);
    cyc(1, 16'hDEAD, 8'hDE, 0, 1);
    chk("t4_valid", out_valid, 0);
    chk("t4_occ", occupancy, 0);
    chk("t4_ready", in_ready, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 16'h5555, 8'hFF, 0);
    chk("t5_ctrl_on", out_ctrl, 8'hFF);
    cyc(0, 0, 0, 1);
    chk("t5_valid", out_valid, 0);
    chk("t5_ctrl", out_ctrl, 0);
    cyc(1, 16'h0303, 8'h03, 0);
    cyc(1, 16'h0404, 8'h04, 0);
    cyc(1, 16'h0505, 8'h05, 0, 1, 1);
    chk("t6_valid", out_valid, 0);
    chk("t6_ready", in_ready, 1);
    chk("t6_ctrl", out_ctrl, 0);
    chk("t6_data", out_data, 0);
    chk("t6_occ", occupancy, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, 16'($urandom), 8'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 40) == 0, $urandom_range(0, 250) == 0);
    cyc(0, 0, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
